pixel_block_packer: RTL and testbench

Front-end stage of the image encryption datapath: accepts an 8-bit pixel stream with a ready/valid handshake and packs 32 consecutive pixels into one 256-bit plaintext block. It drives the CTR-mode Feistel encryptor directly. The first block of a frame is issued with `crypto_trigger` and a latched IV; every later block is issued with `tvalid`. The packer also gates the stream until the round-key schedule is loaded, and handles frame start, frame end and partial final blocks.

---
 rtl/pixel_block_packer_if.sv | 13 +
 rtl/pixel_block_packer.sv | 101 ++++++++++
 tb/tb_pixel_block_packer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_block_packer_if.sv
// pixel_block_packer_if: ready/valid pixel stream (data, start-of-frame, end-of-frame) into the block packer
interface pixel_block_packer_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   s_tvalid;
    logic                   s_tready;
    logic [PIXEL_WIDTH-1:0] s_tdata;
    logic                   s_tuser;
    logic                   s_tlast;

    modport master (output s_tvalid, s_tdata, s_tuser, s_tlast, input s_tready);
    modport slave  (input s_tvalid, s_tdata, s_tuser, s_tlast, output s_tready);
endinterface

// File: rtl/pixel_block_packer.sv
// pixel_block_packer: packs a pixel stream into plaintext blocks for the CTR Feistel encryptor.
// Optional feature: define PACKER_PAD_EN to emit partial final blocks padded with PAD_BYTE.
// Without it, partial final blocks are dropped and err_partial pulses.
module pixel_block_packer #(
    parameter int                     DATA_WIDTH  = 256,
    parameter int                     PIXEL_WIDTH = 8,
    parameter logic [PIXEL_WIDTH-1:0] PAD_BYTE    = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  keys_ready,
    input  logic [DATA_WIDTH-1:0] iv_in,
    pixel_block_packer_if.slave   s,
    output logic                  crypto_trigger,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] plaintext,
    output logic [DATA_WIDTH-1:0] iv,
    output logic                  frame_done,
    output logic [15:0]           blk_cnt,
    output logic                  err_partial
);
    localparam int N  = DATA_WIDTH / PIXEL_WIDTH;
    localparam int IW = $clog2(N);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;
`ifdef PACKER_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    logic [0:0]            state;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         cur_idx;
    logic                  first;
    logic [DATA_WIDTH-1:0] assembly;
    logic [DATA_WIDTH-1:0] filled;
    logic                  xfer;
    logic                  sof;
    logic                  accept;
    logic                  last_lane;
    logic                  partial;
    logic                  emit;
    logic                  first_blk;

    // Stream is gated purely by the key schedule; held low while in reset.
    assign s.s_tready = keys_ready & reset_n;
    assign xfer       = s.s_tvalid & s.s_tready;
    assign sof        = xfer & s.s_tuser;
    assign accept     = sof | (xfer & (state == FILL));
    // A start-of-frame pixel always lands in lane 0, even when restarting mid-frame.
    assign cur_idx    = s.s_tuser ? '0 : idx;
    assign last_lane  = cur_idx == IW'(N - 1);
    assign partial    = accept & s.s_tlast & !last_lane;
    assign emit       = accept & (last_lane | (s.s_tlast & PAD_EN));
    assign first_blk  = sof | first;

    // Block as it stands with the incoming pixel merged in; lanes past it are padding.
    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam int HI = DATA_WIDTH - 1 - g * PIXEL_WIDTH;
        assign filled[HI -: PIXEL_WIDTH] = (IW'(g) < cur_idx)  ? assembly[HI -: PIXEL_WIDTH] :
                                           (IW'(g) == cur_idx) ? s.s_tdata :
                                           PAD_EN              ? PAD_BYTE : assembly[HI -: PIXEL_WIDTH];
    end

    // Frame state, lane index and first-block flag advance on every accepted pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            first    <= 1'b0;
            assembly <= '0;
        end else if (accept) begin
            state    <= s.s_tlast ? IDLE : FILL;
            idx      <= (s.s_tlast | last_lane) ? '0 : cur_idx + IW'(1);
            first    <= first_blk & !emit;
            assembly <= filled;
        end
    end

    // Registered block outputs: emit pulses, the emitted block, the frame IV and block count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crypto_trigger <= 1'b0;
            tvalid         <= 1'b0;
            frame_done     <= 1'b0;
            err_partial    <= 1'b0;
            plaintext      <= '0;
            iv             <= '0;
            blk_cnt        <= '0;
        end else begin
            crypto_trigger <= emit & first_blk;
            tvalid         <= emit & !first_blk;
            frame_done     <= accept & s.s_tlast;
            err_partial    <= (sof & (state == FILL)) | (partial & !PAD_EN);
            if (emit) plaintext <= filled;
            if (sof) iv <= iv_in;
            if (sof | emit) blk_cnt <= (sof ? 16'd0 : blk_cnt) + {15'd0, emit};
        end
    end
endmodule

// File: tb/tb_pixel_block_packer.sv
// tb_pixel_block_packer: scoreboard bench with a frame-level reference model of the packer
module tb_pixel_block_packer;
    localparam int DW = 256;
    localparam int PW = 8;
    localparam int N  = DW / PW;
    localparam logic [7:0] PAD = 8'hEE;
`ifdef PACKER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          keys_ready = 1'b0;
    logic [DW-1:0] iv_in = '0;
    logic          crypto_trigger, tvalid, frame_done, err_partial;
    logic [DW-1:0] plaintext, iv;
    logic [15:0]   blk_cnt;

    pixel_block_packer_if #(.PIXEL_WIDTH(PW)) bus();

    pixel_block_packer #(.DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .PAD_BYTE(PAD)) dut (
        .clk(clk), .reset_n(reset_n), .keys_ready(keys_ready), .iv_in(iv_in), .s(bus),
        .crypto_trigger(crypto_trigger), .tvalid(tvalid), .plaintext(plaintext), .iv(iv),
        .frame_done(frame_done), .blk_cnt(blk_cnt), .err_partial(err_partial)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        bit          trig, tv, fd, err;
        logic [DW-1:0] pt, ivv;
        logic [15:0] cnt;
    } ev_t;
    ev_t q[$];

    int compared = 0;
    int mismatched = 0;

    // reference model: frame-level view of the stream
    bit            in_frame = 0;
    logic [7:0]    cur[$];
    logic [DW-1:0] m_iv = '0;
    logic [DW-1:0] m_pt = '0;
    logic [15:0]   blocks = '0;
    int            drop_pct = 0;

    function automatic void chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] rand_iv();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_beat(input logic [7:0] d, input bit u, input bit l, input int e, input logic [DW-1:0] v);
        bit restart, drop, emit, first;
        ev_t ev;
        restart = 0; drop = 0; emit = 0; first = 0;
        if (u) begin
            restart = in_frame;
            in_frame = 1;
            cur.delete();
            m_iv = v;
            blocks = 0;
        end else if (!in_frame) begin
            return;
        end
        cur.push_back(d);
        if (cur.size() == N || l) begin
            if (cur.size() == N || PAD_EN) begin
                emit = 1;
                first = (blocks == 0);
                for (int i = 0; i < N; i++) m_pt[DW-1-8*i -: 8] = (i < cur.size()) ? cur[i] : PAD;
                blocks++;
            end else begin
                drop = 1;
            end
            cur.delete();
        end
        if (l) in_frame = 0;
        if (restart || drop || emit || l) begin
            ev.c = e; ev.trig = emit & first; ev.tv = emit & !first; ev.fd = l;
            ev.err = restart | drop; ev.pt = m_pt; ev.ivv = m_iv; ev.cnt = blocks;
            q.push_back(ev);
        end
    endfunction

    task automatic send(input logic [7:0] d, input bit u, input bit l, input logic [DW-1:0] v);
        bit acc;
        acc = 0;
        while (!acc) begin
            @(posedge clk); #1;
            keys_ready = ($urandom_range(99) >= drop_pct);
            bus.s_tvalid = 1; bus.s_tdata = d; bus.s_tuser = u; bus.s_tlast = l; iv_in = v;
            acc = keys_ready;
        end
        model_beat(d, u, l, cyc + 1, v);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.s_tvalid = 0; bus.s_tdata = 8'($urandom); bus.s_tuser = 1'($urandom); bus.s_tlast = 1'($urandom);
        keys_ready = 1'($urandom);
    endtask

    task automatic check_zero_outputs();
        chk("rst_crypto_trigger", crypto_trigger, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_partial", err_partial, 0);
        chk("rst_plaintext", plaintext, 0);
        chk("rst_iv", iv, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
    endtask

    task automatic do_reset();
        idle(); idle();
        @(negedge clk); #1;
        reset_n = 0; keys_ready = 1; bus.s_tvalid = 1; bus.s_tuser = 1;
        chk("queue_at_reset", q.size(), 0);
        q.delete(); cur.delete();
        in_frame = 0; m_iv = '0; m_pt = '0; blocks = '0;
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk); #1;
        bus.s_tvalid = 0; reset_n = 1;
    endtask

    // monitor: every pulse cycle must match the next expected event, in the right cycle
    always @(negedge clk) begin
        ev_t e;
        chk("s_tready", bus.s_tready, keys_ready & reset_n);
        if (reset_n) begin
            if (crypto_trigger | tvalid | frame_done | err_partial) begin
                if (q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_pulse: trig=%b tv=%b fd=%b err=%b at cycle %0d, none expected",
                             crypto_trigger, tvalid, frame_done, err_partial, cyc);
                end else begin
                    e = q.pop_front();
                    chk("emit_cycle", cyc, e.c);
                    chk("crypto_trigger", crypto_trigger, e.trig);
                    chk("tvalid", tvalid, e.tv);
                    chk("frame_done", frame_done, e.fd);
                    chk("err_partial", err_partial, e.err);
                    chk("plaintext", plaintext, e.pt);
                    chk("iv", iv, e.ivv);
                    chk("blk_cnt", blk_cnt, e.cnt);
                end
            end else if (q.size() != 0 && q[0].c < cyc) begin
                e = q.pop_front();
                compared++; mismatched++;
                $display("FAIL missing_pulse: nothing seen by cycle %0d, expected event at cycle %0d", cyc, e.c);
            end
        end
    end

    initial begin
        int len;
        bit u, l;
        bus.s_tvalid = 0; bus.s_tdata = '0; bus.s_tuser = 0; bus.s_tlast = 0;
        keys_ready = 1;
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk); #1;
        reset_n = 1;

        // single full frame, pixels 0..31, IV A5..
        drop_pct = 0;
        for (int i = 0; i < N; i++) send(8'(i), i == 0, i == N - 1, i == 0 ? {32{8'hA5}} : rand_iv());
        // 96 pixels back to back: trigger then two tvalid
        for (int i = 0; i < 96; i++) send(8'(i + 7), i == 0, i == 95, rand_iv());
        // SOF waiting on keys_ready
        @(posedge clk); #1;
        keys_ready = 0; bus.s_tvalid = 1; bus.s_tdata = 8'h3C; bus.s_tuser = 1; bus.s_tlast = 0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 40; i++) send(i == 0 ? 8'h3C : 8'(i * 3), i == 0, i == 39, rand_iv());
        // short frame: padded or dropped
        for (int i = 0; i < 10; i++) send(8'(i), i == 0, i == 9, rand_iv());
        // pixels outside a frame are ignored
        for (int i = 0; i < 5; i++) send(8'($urandom), 0, 0, rand_iv());
        // restart at pixel 20, then a clean block
        for (int i = 0; i < 20; i++) send(8'(i), i == 0, 0, rand_iv());
        for (int i = 0; i < N; i++) send(8'(100 + i), i == 0, i == N - 1, rand_iv());
        // reset mid-frame, then a fresh frame
        for (int i = 0; i < 17; i++) send(8'(i), i == 0, 0, rand_iv());
        do_reset();
        for (int i = 0; i < N; i++) send(8'(200 + i), i == 0, i == N - 1, rand_iv());

        // randomized frames with key drops, gaps, restarts and missing tlast
        drop_pct = 15;
        repeat (30) begin
            len = $urandom_range(1, 80);
            repeat ($urandom_range(0, 2)) send(8'($urandom), 0, 0, rand_iv());
            for (int i = 0; i < len; i++) begin
                u = (i == 0) || ($urandom_range(99) == 0);
                l = (i == len - 1) && ($urandom_range(9) != 0);
                send(8'($urandom), u, l, rand_iv());
                if ($urandom_range(9) == 0) idle();
            end
        end
        repeat (5) idle();
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
